// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_pkg
//  Description : Shared constants, FSM encoding and initial-state builder for
//                the Trivium keystream generator.
//                State bit s_n (1-based, as in the cipher description) lives
//                at vector index n-1 of every 288-bit state word.
//  Revision    : 1.0  initial release
// ============================================================================
package trivium_pkg;

  localparam int STATE_W       = 288;
  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int WARMUP_ROUNDS = 1152;

  // First index of the second shift register (s94 -> index 93).
  localparam int IV_BASE       = 93;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } fsm_state_t;

  // s1..s80 = key, s81..s93 = 0, s94..s173 = iv, s174..s285 = 0,
  // s286..s288 = 1.
  function automatic logic [STATE_W-1:0] init_state(
    input logic [KEY_W-1:0] key,
    input logic [IV_W-1:0]  iv
  );
    logic [STATE_W-1:0] s;
    s                          = '0;
    s[KEY_W-1:0]               = key;
    s[IV_BASE+IV_W-1:IV_BASE]  = iv;
    s[STATE_W-1 -: 3]          = 3'b111;
    return s;
  endfunction

endpackage : trivium_pkg
`default_nettype wire

// File: rtl/trivium_round.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_round
//  Description : One purely combinational Trivium round.
//  Ports       : state_in  [288] current state (index n-1 = s_n)
//                state_out [288] state after the round
//                z         [1]   keystream bit produced by this round
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               z
);

  logic t1_lin, t2_lin, t3_lin;
  logic t1, t2, t3;

  // Linear taps feed the output bit; the AND terms only feed back.
  assign t1_lin = state_in[65]  ^ state_in[92];
  assign t2_lin = state_in[161] ^ state_in[176];
  assign t3_lin = state_in[242] ^ state_in[287];
  assign z      = t1_lin ^ t2_lin ^ t3_lin;

  assign t1 = t1_lin ^ (state_in[90]  & state_in[91])  ^ state_in[170];
  assign t2 = t2_lin ^ (state_in[174] & state_in[175]) ^ state_in[263];
  assign t3 = t3_lin ^ (state_in[285] & state_in[286]) ^ state_in[68];

  // Three shift registers: s1..s93, s94..s177, s178..s288. Each takes the
  // feedback from the previous register at its head and drops its last bit.
  assign state_out[92:0]    = {state_in[91:0],    t3};
  assign state_out[176:93]  = {state_in[175:93],  t1};
  assign state_out[287:177] = {state_in[286:177], t2};

endmodule : trivium_round
`default_nettype wire

// File: rtl/trivium_keystream.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_keystream
//  Description : Trivium keystream generator with UNROLL rounds per clock.
//                load -> 1152-round warm-up (busy) -> keystream beats on a
//                valid/ready interface.
//  Ports       : clk       clock
//                reset     asynchronous, active-low reset
//                load      reinitialise from key/iv (any state)
//                key [80]  K1 = key[0]
//                iv  [80]  IV1 = iv[0]
//                busy      warm-up in progress
//                ks_valid  keystream beat available
//                ks_ready  consumer accepts the beat
//                ks_data [UNROLL] keystream bits, [0] earliest
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_keystream
  import trivium_pkg::*;
#(
  parameter int UNROLL = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [KEY_W-1:0]  key,
  input  logic [IV_W-1:0]   iv,
  output logic              busy,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [UNROLL-1:0] ks_data
);

  localparam int WARMUP_CYCLES = WARMUP_ROUNDS / UNROLL;
  localparam int CNT_W         = $clog2(WARMUP_CYCLES + 1);

  fsm_state_t         fsm_state;
  fsm_state_t         fsm_next;
  logic [CNT_W-1:0]   warm_cnt;
  logic [STATE_W-1:0] cipher_state;
  logic [STATE_W-1:0] chain [0:UNROLL];
  logic [UNROLL-1:0]  z_bits;
  logic               warm_last;
  logic               advance;

  // --------------------------------------------------------------------------
  // Round chain: chain[i] is the state before round i of this clock.
  // --------------------------------------------------------------------------
  assign chain[0] = cipher_state;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    trivium_round u_round (
      .state_in  (chain[g]),
      .state_out (chain[g+1]),
      .z         (z_bits[g])
    );
  end

  assign ks_data = z_bits;

  // Final warm-up clock: the counter becomes WARMUP_CYCLES on this edge.
  assign warm_last = (fsm_state == INIT) &&
                     (warm_cnt == CNT_W'(WARMUP_CYCLES - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_state <= IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_next = fsm_state;
    if (load) begin
      fsm_next = INIT;
    end else begin
      case (fsm_state)
        IDLE:    fsm_next = IDLE;
        INIT:    if (warm_last) fsm_next = RUN;
        RUN:     fsm_next = RUN;
        default: fsm_next = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    ks_valid = 1'b0;
    advance  = 1'b0;
    case (fsm_state)
      INIT: begin
        busy    = 1'b1;
        advance = 1'b1;
      end
      RUN: begin
        ks_valid = 1'b1;
        advance  = ks_ready;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Cipher state and warm-up counter. load wins over a handshake, so a beat
  // offered in the same cycle is simply dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cipher_state <= '0;
      warm_cnt     <= '0;
    end else if (load) begin
      cipher_state <= init_state(key, iv);
      warm_cnt     <= '0;
    end else begin
      if (advance) begin
        cipher_state <= chain[UNROLL];
      end
      if (fsm_state == INIT) begin
        warm_cnt <= warm_cnt + CNT_W'(1);
      end
    end
  end

endmodule : trivium_keystream
`default_nettype wire
